// File: rtl/ps2_codes_pkg.sv
// Shared PS/2 scan-code constants and the decoder state encoding.
package ps2_codes_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_ACK = 8'hFA;
  localparam logic [7:0] SC_BAT = 8'hAA;
  localparam logic [7:0] SC_UP  = 8'h75;
  localparam logic [7:0] SC_RT  = 8'h74;
  localparam logic [7:0] SC_LF  = 8'h6B;
  localparam logic [7:0] SC_W   = 8'h1D;
  localparam logic [7:0] SC_D   = 8'h23;
  localparam logic [7:0] SC_A   = 8'h1C;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_seq_timer.sv
// Inter-byte watchdog: counts while run is high, restarts on clear,
// and pulses expire on the cycle the count reaches TIMEOUT_CYCLES-1.
module ps2_seq_timer #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int CNT_W          = 22
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // A clear in the same cycle suppresses expiry, so a byte arriving just in time still counts.
  assign expire = run && !clear && (count == LAST);

  always_ff @(posedge Clock) begin
    if (Reset || clear || !run || expire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_move_decoder.sv
// Turns the PS/2 make/break byte stream into held-level move commands
// (forward/right/left) for the game core, including E0-extended arrow keys.
module ps2_move_decoder
  import ps2_codes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int CNT_W          = 22
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  output logic       moveForward,
  output logic       moveRight,
  output logic       moveLeft,
  output logic       key_event,
  output logic       seq_error
);

  localparam logic [7:0] SC_ERR0 = 8'h00;
  localparam logic [7:0] SC_ERR1 = 8'hFF;

  localparam int UP_ARR = 5;
  localparam int RT_ARR = 4;
  localparam int LF_ARR = 3;
  localparam int W_KEY  = 2;
  localparam int D_KEY  = 1;
  localparam int A_KEY  = 0;

  ps2_state_e state, state_next;
  logic [5:0] held, held_next;
  logic       err_next;
  logic       timer_clear, timer_run, timeout;
  logic       fwd_next, rt_raw, lf_raw;

  assign timer_run   = Enable && (state != IDLE);
  assign timer_clear = !Enable || ps2_byte_valid || (state == IDLE);

  ps2_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .Clock (Clock),
    .Reset (Reset),
    .clear (timer_clear),
    .run   (timer_run),
    .expire(timeout)
  );

  always_comb begin
    state_next = state;
    held_next  = held;
    err_next   = 1'b0;
    if (!Enable) begin
      state_next = IDLE;
      held_next  = '0;
    end else if (ps2_byte_valid) begin
      if (ps2_byte == SC_ACK || ps2_byte == SC_BAT) begin
        state_next = state;
      end else if (ps2_byte == SC_ERR0 || ps2_byte == SC_ERR1) begin
        state_next = IDLE;
        held_next  = '0;
        err_next   = 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (ps2_byte == SC_EXT) begin
              state_next = EXT;
            end else if (ps2_byte == SC_BRK) begin
              state_next = BRK;
            end else begin
              case (ps2_byte)
                SC_W:    held_next[W_KEY] = 1'b1;
                SC_D:    held_next[D_KEY] = 1'b1;
                SC_A:    held_next[A_KEY] = 1'b1;
                default: held_next = held;
              endcase
            end
          end
          EXT: begin
            state_next = IDLE;
            if (ps2_byte == SC_BRK) begin
              state_next = EXT_BRK;
            end else begin
              case (ps2_byte)
                SC_UP:   held_next[UP_ARR] = 1'b1;
                SC_RT:   held_next[RT_ARR] = 1'b1;
                SC_LF:   held_next[LF_ARR] = 1'b1;
                default: held_next = held;
              endcase
            end
          end
          BRK: begin
            state_next = IDLE;
            case (ps2_byte)
              SC_W:    held_next[W_KEY] = 1'b0;
              SC_D:    held_next[D_KEY] = 1'b0;
              SC_A:    held_next[A_KEY] = 1'b0;
              default: held_next = held;
            endcase
          end
          EXT_BRK: begin
            state_next = IDLE;
            case (ps2_byte)
              SC_UP:   held_next[UP_ARR] = 1'b0;
              SC_RT:   held_next[RT_ARR] = 1'b0;
              SC_LF:   held_next[LF_ARR] = 1'b0;
              default: held_next = held;
            endcase
          end
          default: state_next = IDLE;
        endcase
      end
    end else if (timeout) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end
  end

  assign fwd_next = held_next[UP_ARR] | held_next[W_KEY];
  assign rt_raw   = held_next[RT_ARR] | held_next[D_KEY];
  assign lf_raw   = held_next[LF_ARR] | held_next[A_KEY];

  // Opposing directions cancel each other; forward is independent of that.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      held        <= '0;
      moveForward <= 1'b0;
      moveRight   <= 1'b0;
      moveLeft    <= 1'b0;
      key_event   <= 1'b0;
      seq_error   <= 1'b0;
    end else begin
      state       <= state_next;
      held        <= held_next;
      moveForward <= fwd_next;
      moveRight   <= rt_raw & ~lf_raw;
      moveLeft    <= lf_raw & ~rt_raw;
      key_event   <= Enable && (held_next != held);
      seq_error   <= err_next;
    end
  end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Self-checking bench for ps2_move_decoder: vector table driven through a
// scoreboard queue, plus hand-written timeout sequences.
module tb_ps2_move_decoder;
  import ps2_codes_pkg::*;

  localparam int TOUT = 16;

  logic       Clock;
  logic       Reset;
  logic       Enable;
  logic [7:0] ps2Byte;
  logic       ps2Valid;
  logic       moveForward, moveRight, moveLeft, keyEvent, seqError;

  int checks = 0;
  int errors = 0;

  // Expected bits are {forward, right, left, key_event, seq_error}.
  typedef struct {
    logic       rst;
    logic       en;
    logic       vld;
    logic [7:0] b;
    logic [4:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [4:0] exp;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t expQ[$];

  ps2_move_decoder #(
    .TIMEOUT_CYCLES(TOUT),
    .CNT_W         (5)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Enable        (Enable),
    .ps2_byte      (ps2Byte),
    .ps2_byte_valid(ps2Valid),
    .moveForward   (moveForward),
    .moveRight     (moveRight),
    .moveLeft      (moveLeft),
    .key_event     (keyEvent),
    .seq_error     (seqError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic addVec(input logic rst, input logic en, input logic vld,
                        input logic [7:0] b, input logic [4:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.b = b; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic vld,
                               input logic [7:0] b, input logic [4:0] exp, input string name);
    exp_t e;
    Reset    = rst;
    Enable   = en;
    ps2Valid = vld;
    ps2Byte  = b;
    e.exp  = exp;
    e.name = name;
    expQ.push_back(e);
    @(negedge Clock);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [4:0] act;
    e   = expQ.pop_front();
    act = {moveForward, moveRight, moveLeft, keyEvent, seqError};
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: got fwd/rt/lf/kev/err=%b expected %b", e.name, act, e.exp);
    end
  endtask

  // Scoreboard consumer: each pushed expectation is due just after the next rising edge.
  always @(posedge Clock) begin
    if (expQ.size() != 0) begin
      #1;
      checkOutput();
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  waited;
    bit  seen;

    Reset = 1'b1; Enable = 1'b0; ps2Valid = 1'b0; ps2Byte = 8'h00;

    addVec(1, 0, 0, 8'h00, 5'b00000, "reset cycle 1");
    addVec(1, 0, 0, 8'h00, 5'b00000, "reset cycle 2");
    addVec(0, 1, 1, SC_W,   5'b10010, "w make");
    addVec(0, 1, 1, SC_W,   5'b10000, "w typematic");
    addVec(0, 1, 1, SC_BRK, 5'b10000, "w break prefix");
    addVec(0, 1, 1, SC_W,   5'b00010, "w break");
    addVec(0, 1, 1, SC_EXT, 5'b00000, "rt ext prefix");
    addVec(0, 1, 1, SC_RT,  5'b01010, "rt arrow make");
    addVec(0, 1, 1, SC_EXT, 5'b01000, "rt ext brk e0");
    addVec(0, 1, 1, SC_BRK, 5'b01000, "rt ext brk f0");
    addVec(0, 1, 1, SC_RT,  5'b00010, "rt arrow break");
    addVec(0, 1, 1, SC_RT,  5'b00000, "keypad 74 ignored");
    addVec(0, 1, 1, SC_A,   5'b00110, "a make");
    addVec(0, 1, 1, SC_EXT, 5'b00100, "conflict e0");
    addVec(0, 1, 1, SC_RT,  5'b00010, "conflict lr cancel");
    addVec(0, 1, 1, SC_BRK, 5'b00000, "conflict brk prefix");
    addVec(0, 1, 1, SC_A,   5'b01010, "a break rt remains");
    addVec(0, 1, 1, SC_EXT, 5'b01000, "rt cleanup e0");
    addVec(0, 1, 1, SC_BRK, 5'b01000, "rt cleanup f0");
    addVec(0, 1, 1, SC_RT,  5'b00010, "rt cleanup break");
    addVec(0, 1, 1, SC_EXT, 5'b00000, "lf ext prefix");
    addVec(0, 1, 1, SC_LF,  5'b00110, "lf arrow make");
    addVec(0, 1, 1, SC_EXT, 5'b00100, "lf brk e0");
    addVec(0, 1, 1, SC_BRK, 5'b00100, "lf brk f0");
    addVec(0, 1, 1, SC_LF,  5'b00010, "lf arrow break");
    addVec(0, 1, 1, SC_W,   5'b10010, "w make before ff");
    addVec(0, 1, 1, SC_D,   5'b11010, "d make before ff");
    addVec(0, 1, 1, 8'hFF,  5'b00011, "ff clears all");
    addVec(0, 1, 0, 8'h00,  5'b00000, "error pulse width");
    addVec(0, 1, 1, SC_EXT, 5'b00000, "up e0");
    addVec(0, 1, 1, SC_ACK, 5'b00000, "ack ignored");
    addVec(0, 1, 1, SC_BAT, 5'b00000, "bat ignored");
    addVec(0, 1, 1, SC_UP,  5'b10010, "up arrow after ack bat");
    addVec(0, 1, 1, SC_EXT, 5'b10000, "up brk e0");
    addVec(0, 1, 1, SC_BRK, 5'b10000, "up brk f0");
    addVec(0, 1, 1, SC_UP,  5'b00010, "up arrow break");
    addVec(0, 1, 1, SC_D,   5'b01010, "d make before 00");
    addVec(0, 1, 1, SC_EXT, 5'b01000, "e0 before 00");
    addVec(0, 1, 1, 8'h00,  5'b00011, "00 in ext clears");
    addVec(0, 1, 0, 8'h00,  5'b00000, "after 00 idle");
    addVec(0, 1, 1, SC_D,   5'b01010, "d make before disable");
    addVec(0, 0, 0, 8'h00,  5'b00000, "enable drop");
    addVec(0, 0, 1, SC_D,   5'b00000, "byte while disabled");
    addVec(0, 1, 0, 8'h00,  5'b00000, "resume no stale key");
    addVec(0, 1, 1, SC_EXT, 5'b00000, "e0 before reset");
    addVec(1, 1, 0, 8'h00,  5'b00000, "reset mid sequence");
    addVec(0, 1, 1, SC_UP,  5'b00000, "75 after reset keypad");
    addVec(1, 1, 1, SC_W,   5'b00000, "reset beats valid");
    addVec(0, 1, 1, SC_W,   5'b10010, "w make after reset");
    addVec(0, 1, 1, SC_BRK, 5'b10000, "w cleanup f0");
    addVec(0, 1, 1, SC_W,   5'b00010, "w cleanup break");

    @(negedge Clock);
    foreach (vecs[i])
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Timeout after a lone E0 while D is held: held keys survive, FSM returns to IDLE.
    applyStimulus(0, 1, 1, SC_D,   5'b01010, "d make before timeout");
    applyStimulus(0, 1, 1, SC_EXT, 5'b01000, "e0 before timeout");
    ps2Valid = 1'b0;
    waited = 0;
    seen   = 1'b0;
    for (int n = 1; n <= 4 * TOUT && !seen; n++) begin
      @(posedge Clock); #2;
      if (seqError) begin
        seen   = 1'b1;
        waited = n;
      end
    end
    checks++;
    if (!seen || waited < TOUT - 1 || waited > TOUT + 1) begin
      errors++;
      $display("[TB] FAIL timeout latency: got seen=%0d after %0d cycles expected about %0d",
               seen, waited, TOUT);
    end
    checks++;
    if ({moveForward, moveRight, moveLeft} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL timeout keeps held: got %b expected 010",
               {moveForward, moveRight, moveLeft});
    end
    @(posedge Clock); #2;
    checks++;
    if (seqError !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout pulse width: got %b expected 0", seqError);
    end
    @(negedge Clock);
    applyStimulus(0, 1, 1, SC_W,   5'b11010, "w make after timeout");
    applyStimulus(0, 1, 1, SC_BRK, 5'b11000, "post timeout f0");
    applyStimulus(0, 1, 1, SC_W,   5'b01010, "post timeout w break");
    applyStimulus(0, 1, 1, SC_BRK, 5'b01000, "post timeout f0 d");
    applyStimulus(0, 1, 1, SC_D,   5'b00010, "post timeout d break");
    ps2Valid = 1'b0;

    // The watchdog must stay quiet while the decoder sits in IDLE.
    seen = 1'b0;
    for (int n = 0; n < 3 * TOUT; n++) begin
      @(posedge Clock); #2;
      if (seqError) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL idle no timeout: got seq_error pulse expected none");
    end

    @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
